// File: rtl/invader_fleet_if.sv
// Hit handshake between the collision logic (master) and the invader formation (slave).
interface invader_fleet_if;
    logic       hit_valid;
    logic [4:0] hit_index;
    logic       hit_ack;

    modport master (output hit_valid, output hit_index, input hit_ack);
    modport slave  (input hit_valid, input hit_index, output hit_ack);
endinterface

// File: rtl/invader_fleet.sv
// Formation controller for the 4x5 invader grid: alive mask, march, descent and
// speed-up as invaders die. Feeds alive mask and lowest occupied line to the game FSM.
module invader_fleet #(
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 400,
    parameter int X_START    = 200,
    parameter int STEP       = 8,
    parameter int MIN_PERIOD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           game_state,
    input  logic                 tick,
    invader_fleet_if.slave       hit,
    output logic [19:0]          alive,
    output logic [9:0]           fleet_x,
    output logic                 fleet_dir,
    output logic [3:0]           top_line,
    output logic [3:0]           invader_line,
    output logic                 step_pulse
);
    localparam int CW = $clog2(MIN_PERIOD + 21);
    localparam int EMPTY_PERIOD = (MIN_PERIOD > 1) ? (MIN_PERIOD - 1) : 1;

    typedef enum logic [1:0] {
        GS_BEGIN = 2'b00,
        GS_CONT  = 2'b01,
        GS_WIN   = 2'b10,
        GS_OVER  = 2'b11
    } game_state_t;

    game_state_t gs;
    assign gs = game_state_t'(game_state);

    logic [19:0]   alive_reg, alive_next;
    logic [9:0]    fleet_x_reg, fleet_x_next;
    logic          dir_reg, dir_next;
    logic [3:0]    top_line_reg, top_line_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          ack_reg, ack_next;
    logic          step_reg, step_next;

    logic [4:0]    live_count;
    logic [CW-1:0] period;
    logic [CW:0]   cnt_inc;
    logic [10:0]   x_plus;
    logic          right_ok, left_ok;
    logic [31:0]   alive_pad;
    logic          hit_ok;
    logic [19:0]   kill_mask;
    logic [3:0]    row_any;
    logic [1:0]    low_row;
    logic [4:0]    line_sum;
    logic [3:0]    top_sat_inc;

    always_comb begin
        live_count = '0;
        for (int i = 0; i < 20; i++) begin
            live_count = live_count + {4'b0, alive_reg[i]};
        end
    end

    // Speed-up: one fewer tick per step for every invader killed.
    always_comb begin
        if (live_count == 5'd0) begin
            period = CW'(EMPTY_PERIOD);
        end else begin
            period = CW'(MIN_PERIOD + int'(live_count) - 1);
        end
    end

    assign cnt_inc     = {1'b0, cnt_reg} + {{CW{1'b0}}, 1'b1};
    assign x_plus      = {1'b0, fleet_x_reg} + 11'(STEP);
    assign right_ok    = (x_plus <= 11'(X_MAX));
    assign left_ok     = (fleet_x_reg >= 10'(X_MIN + STEP));
    assign top_sat_inc = (top_line_reg == 4'd15) ? 4'd15 : top_line_reg + 4'd1;

    assign alive_pad = {12'b0, alive_reg};
    assign hit_ok    = (gs == GS_CONT) && hit.hit_valid &&
                       (hit.hit_index < 5'd20) && alive_pad[hit.hit_index];
    assign kill_mask = 20'b1 << hit.hit_index;

    always_comb begin
        alive_next    = alive_reg;
        fleet_x_next  = fleet_x_reg;
        dir_next      = dir_reg;
        top_line_next = top_line_reg;
        cnt_next      = cnt_reg;
        ack_next      = 1'b0;
        step_next     = 1'b0;
        case (gs)
            GS_BEGIN: begin
                alive_next    = 20'hFFFFF;
                fleet_x_next  = 10'(X_START);
                dir_next      = 1'b0;
                top_line_next = 4'd0;
                cnt_next      = '0;
            end
            GS_CONT: begin
                if (tick) begin
                    if (cnt_inc >= {1'b0, period}) begin
                        cnt_next  = '0;
                        step_next = 1'b1;
                        if (!dir_reg) begin
                            if (right_ok) begin
                                fleet_x_next = x_plus[9:0];
                            end else begin
                                top_line_next = top_sat_inc;
                                dir_next      = 1'b1;
                            end
                        end else begin
                            if (left_ok) begin
                                fleet_x_next = fleet_x_reg - 10'(STEP);
                            end else begin
                                top_line_next = top_sat_inc;
                                dir_next      = 1'b0;
                            end
                        end
                    end else begin
                        cnt_next = cnt_inc[CW-1:0];
                    end
                end
                if (hit_ok) begin
                    alive_next = alive_reg & ~kill_mask;
                    ack_next   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive_reg    <= 20'hFFFFF;
            fleet_x_reg  <= 10'(X_START);
            dir_reg      <= 1'b0;
            top_line_reg <= 4'd0;
            cnt_reg      <= '0;
            ack_reg      <= 1'b0;
            step_reg     <= 1'b0;
        end else begin
            alive_reg    <= alive_next;
            fleet_x_reg  <= fleet_x_next;
            dir_reg      <= dir_next;
            top_line_reg <= top_line_next;
            cnt_reg      <= cnt_next;
            ack_reg      <= ack_next;
            step_reg     <= step_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign row_any[gi] = |alive_reg[gi*5 +: 5];
        end
    endgenerate

    // Lowest occupied row; an empty grid reports row 0 so the line falls back to top_line.
    always_comb begin
        if (row_any[3])      low_row = 2'd3;
        else if (row_any[2]) low_row = 2'd2;
        else if (row_any[1]) low_row = 2'd1;
        else                 low_row = 2'd0;
    end

    assign line_sum     = {1'b0, top_line_reg} + {3'b0, low_row};
    assign invader_line = (line_sum > 5'd15) ? 4'd15 : line_sum[3:0];

    assign alive       = alive_reg;
    assign fleet_x     = fleet_x_reg;
    assign fleet_dir   = dir_reg;
    assign top_line    = top_line_reg;
    assign step_pulse  = step_reg;
    assign hit.hit_ack = ack_reg;
endmodule

// File: tb/tb_invader_fleet.sv
// Scoreboard bench for invader_fleet: a per-cycle reference model pushes the expected
// post-edge view, and a monitor pops and compares it after every rising edge.
module tb_invader_fleet;
    localparam int X_MIN      = 0;
    localparam int X_MAX      = 400;
    localparam int X_START    = 200;
    localparam int STEP       = 8;
    localparam int MIN_PERIOD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  game_state = 2'b00;
    logic        tick = 1'b0;
    logic [19:0] alive;
    logic [9:0]  fleet_x;
    logic        fleet_dir;
    logic [3:0]  top_line;
    logic [3:0]  invader_line;
    logic        step_pulse;

    invader_fleet_if hif();

    invader_fleet #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .X_START(X_START),
        .STEP(STEP), .MIN_PERIOD(MIN_PERIOD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .game_state(game_state),
        .tick(tick),
        .hit(hif),
        .alive(alive),
        .fleet_x(fleet_x),
        .fleet_dir(fleet_dir),
        .top_line(top_line),
        .invader_line(invader_line),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ack;
        int step;
        int alive;
        int x;
        int dir;
        int top;
        int line;
    } snap_t;

    snap_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: the formation as plain numbers.
    bit m_alive[20];
    int m_x, m_dir, m_top, m_cnt;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, expv, expv, $time);
        end
    endtask

    function automatic int count_alive();
        int n = 0;
        for (int i = 0; i < 20; i++) n += m_alive[i];
        return n;
    endfunction

    function automatic int pack_alive();
        int v = 0;
        for (int i = 0; i < 20; i++) if (m_alive[i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int expected_line();
        int deepest = -1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++)
                if (m_alive[r*5+c]) deepest = r;
        if (deepest < 0) return m_top;
        return (m_top + deepest > 15) ? 15 : m_top + deepest;
    endfunction

    function automatic int current_period();
        int n = count_alive();
        if (n == 0) return (MIN_PERIOD - 1 < 1) ? 1 : MIN_PERIOD - 1;
        return MIN_PERIOD + n - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 20; i++) m_alive[i] = 1'b1;
        m_x = X_START; m_dir = 0; m_top = 0; m_cnt = 0;
    endtask

    task automatic model_descend();
        m_top = (m_top >= 15) ? 15 : m_top + 1;
        m_dir = 1 - m_dir;
    endtask

    // Drive one cycle of stimulus and queue what the DUT should show after the edge.
    task automatic drive(input int gs, input bit tk, input bit hv, input int idx);
        snap_t s;
        int period;
        @(negedge clk);
        game_state    = gs[1:0];
        tick          = tk;
        hif.hit_valid = hv;
        hif.hit_index = idx[4:0];
        s.ack = 0;
        s.step = 0;
        if (gs == 0) begin
            model_reset();
        end else if (gs == 1) begin
            period = current_period();
            if (hv && idx < 20) s.ack = m_alive[idx] ? 1 : 0;
            if (tk) begin
                if (m_cnt + 1 >= period) begin
                    s.step = 1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (s.step == 1) begin
                if (m_dir == 0) begin
                    if (m_x + STEP <= X_MAX) m_x += STEP;
                    else model_descend();
                end else begin
                    if (m_x - STEP >= X_MIN) m_x -= STEP;
                    else model_descend();
                end
            end
            if (s.ack == 1) m_alive[idx] = 1'b0;
        end
        s.alive = pack_alive();
        s.x     = m_x;
        s.dir   = m_dir;
        s.top   = m_top;
        s.line  = expected_line();
        exp_q.push_back(s);
    endtask

    initial begin : monitor
        snap_t s;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                chk("hit_ack", int'(hif.hit_ack), s.ack);
                chk("step_pulse", int'(step_pulse), s.step);
                chk("alive", int'(alive), s.alive);
                chk("fleet_x", int'(fleet_x), s.x);
                chk("fleet_dir", int'(fleet_dir), s.dir);
                chk("top_line", int'(top_line), s.top);
                chk("invader_line", int'(invader_line), s.line);
                $display("cyc t=%0t ack=%0d step=%0d alive=%05h x=%0d dir=%0d top=%0d line=%0d",
                         $time, hif.hit_ack, step_pulse, alive, fleet_x, fleet_dir,
                         top_line, invader_line);
            end
        end
    end

    task automatic check_reset_view(input string tag);
        chk({tag, "_alive"}, int'(alive), 20'hFFFFF);
        chk({tag, "_fleet_x"}, int'(fleet_x), X_START);
        chk({tag, "_dir"}, int'(fleet_dir), 0);
        chk({tag, "_top"}, int'(top_line), 0);
        chk({tag, "_line"}, int'(invader_line), 3);
        chk({tag, "_ack"}, int'(hif.hit_ack), 0);
        chk({tag, "_step"}, int'(step_pulse), 0);
    endtask

    initial begin : stimulus
        int gs_r, period;
        hif.hit_valid = 1'b0;
        hif.hit_index = 5'd0;
        model_reset();

        // Power-on reset, with CONT stimulus that must be ignored.
        game_state = 2'b01; tick = 1'b1; hif.hit_valid = 1'b1; hif.hit_index = 5'd4;
        repeat (3) @(posedge clk);
        #2;
        check_reset_view("por");
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) drive(0, 1, 1, 2);

        // Full grid: 21 ticks per step.
        for (int k = 0; k < 21; k++) drive(1, 1, 0, 0);
        for (int k = 0; k < 20; k++) drive(1, 1, 0, 0);

        // Accepted hit, then a repeat and an out-of-range index.
        drive(1, 0, 1, 7);
        drive(1, 0, 0, 0);
        drive(1, 0, 1, 7);
        drive(1, 0, 1, 25);
        drive(1, 0, 0, 0);

        // Clear row 3 so the lowest line moves up.
        for (int k = 15; k < 20; k++) drive(1, 0, 1, k);
        drive(1, 0, 0, 0);

        // Asynchronous reset mid-game, away from any clock edge.
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_view("async");
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Long uninterrupted march: edge bounce at X_MAX, descents, line saturation.
        for (int k = 0; k < 20000 && m_top < 13; k++) drive(1, 1, 0, 0);
        for (int k = 0; k < 50; k++) drive(1, 1, 0, 0);

        // Formation reset in the middle of a hit: no ack.
        drive(0, 1, 1, 3);
        drive(1, 0, 1, 3);

        // Random play.
        for (int k = 0; k < 2500; k++) begin
            gs_r = $urandom_range(0, 199);
            if (gs_r < 2) gs_r = 0;
            else if (gs_r < 6) gs_r = 2 + $urandom_range(0, 1);
            else gs_r = 1;
            drive(gs_r, bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 24));
        end

        // Hit and step in the same edge, then GAMEOVER freezes everything.
        drive(0, 0, 0, 0);
        drive(1, 0, 1, 0);
        period = current_period();
        for (int k = 0; k < 40 && m_cnt + 1 < period; k++) drive(1, 1, 0, 0);
        drive(1, 1, 1, 19);
        for (int k = 0; k < 20; k++) drive(3, 1, 1, $urandom_range(0, 19));
        for (int k = 0; k < 10; k++) drive(2, 1, 1, $urandom_range(0, 19));

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
